dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Round-robin arbiter that shares one data memory port among N_p pipelined cores.
- Each core's data-memory handshake (valid/wen/byte_not_word/yumi request side; valid/read_data/yumi response side) connects to one requester slot.
- Exactly one transaction is outstanding at the memory at a time.
- Sits between the cores' memory stage and the single data memory instance.

Parameters:
- N_p, 4, number of requesting cores (2..8).
- TIMEOUT_p, 255, maximum cycles waiting for a memory response before error_o is set (8-bit counter).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid_i  in  N_p  per-core request valid
- req_wen_i  in  N_p  per-core store (1) / load (0)
- req_byte_i  in  N_p  per-core byte_not_word
- req_addr_i  in  32*N_p  per-core address, slice k = [32k+:32]
- req_wdata_i  in  32*N_p  per-core store data
- req_yumi_o  out  N_p  request accepted by memory (one-hot pulse)
- rsp_valid_o  out  N_p  response valid to owner (one-hot)
- rsp_data_o  out  32  read data, broadcast to all cores
- req_yumi_i  in  N_p  core acknowledges response
- mem_valid_o  out  1  request valid to memory
- mem_wen_o  out  1  store enable
- mem_byte_o  out  1  byte_not_word
- mem_addr_o  out  32  address
- mem_wdata_o  out  32  store data
- mem_yumi_o  out  1  acknowledge memory response
- mem_yumi_i  in  1  memory accepted request
- mem_valid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory read data
- grant_id_o  out  $clog2(N_p)  current owner index
- busy_o  out  1  state != IDLE
- error_o  out  1  sticky response-timeout flag

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, rr_ptr=0, owner=0, latched fields=0, timeout count=0, error_o=0. All outputs are 0 during and after reset until a grant. The memory shares this reset, so no cleanup of an outstanding transaction is done.
- States: IDLE, ISSUE, RESP.
- IDLE → ISSUE:
  - Trigger: any req_valid_i bit set.
  - Owner selection: the first set bit scanning rr_ptr, rr_ptr+1, … mod N_p.
  - The arbiter latches owner, addr, wdata, wen and byte from that slot.
  - Grant-to-memory latency is 1 cycle.
- ISSUE:
  - mem_valid_o=1; mem_* outputs are driven from latched fields.
  - When mem_yumi_i=1: req_yumi_o[owner]=1 combinationally that cycle, then next state is RESP.
- Response window: (state==RESP) or (state==ISSUE && mem_yumi_i).
  - Inside the window: rsp_valid_o[owner]=mem_valid_i, rsp_data_o=mem_rdata_i, mem_yumi_o=mem_valid_i & req_yumi_i[owner].
  - Outside the window: rsp_valid_o=0, mem_yumi_o=0, rsp_data_o=0.
- Completion: mem_yumi_o==1 ends the transaction.
  - Next state is IDLE and rr_ptr=(owner+1) mod N_p.
  - This also holds when yumi and valid arrive in the same ISSUE cycle.
- Stores: the memory still returns valid. The same response/ack sequence applies, and rsp_data_o is don't-care to cores.
- Owner stall: if the owner withholds req_yumi_i, mem_yumi_o stays 0 and the arbiter holds in RESP.
- Requester rules:
  - A requester must hold req_valid_i and its fields until req_yumi_o.
  - Fields are latched at grant, so changes after grant are ignored.
  - A non-owner's req_valid_i has no effect until IDLE.
- Back-to-back: the cycle after completion is IDLE; the earliest next grant is on that cycle (one dead cycle on mem_valid_o between transactions).
- Fairness: each of the other N_p-1 requesters is served at most once before a waiting requester is served again.
- Timeout:
  - The counter increments each cycle in RESP while mem_valid_i==0 and clears on entering RESP.
  - When it reaches TIMEOUT_p, error_o is set. error_o is sticky until reset.
  - The FSM keeps waiting after a timeout.
- grant_id_o=owner, held after completion until the next grant.

Test Plan:
- Single load: core1 requests addr 0x40, memory yumi at cycle 3 and valid with 0xDEADBEEF at cycle 5, core1 yumi immediately → req_yumi_o=0b0010 at cycle 3, rsp_valid_o=0b0010 and rsp_data_o=0xDEADBEEF at cycle 5, IDLE at cycle 6, rr_ptr=2.
- All four cores request continuously with a 1-cycle memory → grant order 0,1,2,3,0; mem_valid_o shows a dead cycle between transactions; no core is starved.
- Store from core2 (wen=1, byte=1, wdata 0xAB) → mem_wen_o=1, mem_byte_o=1, mem_wdata_o=0xAB; completes on memory valid plus core2 yumi.
- Owner withholds req_yumi_i for 3 cycles while mem_valid_i=1 → mem_yumi_o=0 for those cycles and state stays RESP; completes on the first ack.
- Same-cycle mem_yumi_i and mem_valid_i in ISSUE → req_yumi_o, rsp_valid_o and mem_yumi_o all assert that cycle; state returns to IDLE next cycle.
- Two further checks:
  - TIMEOUT_p=4 with no memory response → error_o=1 after 4 RESP cycles and stays 1 after a late response.
  - reset=0 asserted mid-RESP → all outputs 0 next cycle and rr_ptr=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single data-memory port among N_p cores.
// One transaction is in flight at a time: grant in IDLE, issue, then wait for the response.
module dmem_arbiter #(
    parameter int N_p       = 4,
    parameter int TIMEOUT_p = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_p-1:0]         req_valid_i,
    input  logic [N_p-1:0]         req_wen_i,
    input  logic [N_p-1:0]         req_byte_i,
    input  logic [32*N_p-1:0]      req_addr_i,
    input  logic [32*N_p-1:0]      req_wdata_i,
    output logic [N_p-1:0]         req_yumi_o,
    output logic [N_p-1:0]         rsp_valid_o,
    output logic [31:0]            rsp_data_o,
    input  logic [N_p-1:0]         req_yumi_i,
    output logic                   mem_valid_o,
    output logic                   mem_wen_o,
    output logic                   mem_byte_o,
    output logic [31:0]            mem_addr_o,
    output logic [31:0]            mem_wdata_o,
    output logic                   mem_yumi_o,
    input  logic                   mem_yumi_i,
    input  logic                   mem_valid_i,
    input  logic [31:0]            mem_rdata_i,
    output logic [$clog2(N_p)-1:0] grant_id_o,
    output logic                   busy_o,
    output logic                   error_o
);
    localparam int IW = $clog2(N_p);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_reg;
    logic [IW-1:0] rr_ptr_reg;
    logic [IW-1:0] owner_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic          wen_reg;
    logic          byte_reg;
    logic [7:0]    tmo_cnt_reg;
    logic          error_reg;

    logic [IW-1:0] pick;
    logic          pick_found;
    logic [IW:0]   cand;
    logic [N_p-1:0] owner_onehot;
    logic          accept;
    logic          window;
    logic          done;
    logic [IW-1:0] rr_ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_p; gi++) begin : g_onehot
            assign owner_onehot[gi] = (owner_reg == IW'(gi));
        end
    endgenerate

    // First requester at or after rr_ptr, wrapping modulo N_p.
    always_comb begin
        pick       = rr_ptr_reg;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 0; i < N_p; i++) begin
            cand = {1'b0, rr_ptr_reg} + (IW+1)'(i);
            if (cand >= (IW+1)'(N_p)) begin
                cand = cand - (IW+1)'(N_p);
            end
            if (!pick_found && req_valid_i[cand[IW-1:0]]) begin
                pick       = cand[IW-1:0];
                pick_found = 1'b1;
            end
        end
    end

    // The response may arrive in the very cycle the memory accepts the request.
    assign accept = (state_reg == ISSUE) && mem_yumi_i;
    assign window = (state_reg == RESP) || accept;
    assign done   = window && mem_valid_i && |(req_yumi_i & owner_onehot);

    assign rr_ptr_next = (owner_reg == IW'(N_p - 1)) ? '0 : owner_reg + IW'(1);

    assign req_yumi_o  = accept ? owner_onehot : '0;
    assign rsp_valid_o = (window && mem_valid_i) ? owner_onehot : '0;
    assign rsp_data_o  = window ? mem_rdata_i : '0;
    assign mem_yumi_o  = done;
    assign mem_valid_o = (state_reg == ISSUE);
    assign mem_wen_o   = wen_reg;
    assign mem_byte_o  = byte_reg;
    assign mem_addr_o  = addr_reg;
    assign mem_wdata_o = wdata_reg;
    assign grant_id_o  = owner_reg;
    assign busy_o      = (state_reg != IDLE);
    assign error_o     = error_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            owner_reg   <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wen_reg     <= 1'b0;
            byte_reg    <= 1'b0;
            tmo_cnt_reg <= '0;
            error_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        owner_reg <= pick;
                        addr_reg  <= req_addr_i[32*pick +: 32];
                        wdata_reg <= req_wdata_i[32*pick +: 32];
                        wen_reg   <= req_wen_i[pick];
                        byte_reg  <= req_byte_i[pick];
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (done) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= rr_ptr_next;
                    end else if (accept) begin
                        state_reg   <= RESP;
                        tmo_cnt_reg <= '0;
                    end
                end
                RESP: begin
                    if (done) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= rr_ptr_next;
                    end else if (!mem_valid_i && tmo_cnt_reg != 8'(TIMEOUT_p)) begin
                        // Counter saturates at the limit; error stays set, FSM keeps waiting.
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                        if (tmo_cnt_reg + 8'd1 == 8'(TIMEOUT_p)) begin
                            error_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_dmem_arbiter;
    localparam int N   = 4;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid_i, req_wen_i, req_byte_i, req_yumi_i;
    logic [32*N-1:0] req_addr_i, req_wdata_i;
    logic [N-1:0]    req_yumi_o, rsp_valid_o;
    logic [31:0]     rsp_data_o;
    logic            mem_valid_o, mem_wen_o, mem_byte_o, mem_yumi_o;
    logic [31:0]     mem_addr_o, mem_wdata_o;
    logic            mem_yumi_i, mem_valid_i;
    logic [31:0]     mem_rdata_i;
    logic [1:0]      grant_id_o;
    logic            busy_o, error_o;

    int errs   = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.N_p(N), .TIMEOUT_p(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_byte_i(req_byte_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_yumi_o(req_yumi_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .req_yumi_i(req_yumi_i),
        .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_byte_o(mem_byte_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_yumi_o(mem_yumi_o),
        .mem_yumi_i(mem_yumi_i), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
        .grant_id_o(grant_id_o), .busy_o(busy_o), .error_o(error_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_i = '0; req_wen_i = '0; req_byte_i = '0; req_yumi_i = '0;
        req_addr_i = '0; req_wdata_i = '0;
        mem_yumi_i = 1'b0; mem_valid_i = 1'b0; mem_rdata_i = '0;
    endtask

    // ---------------- behavioural model (transaction level) ----------------
    bit          m_open, m_took, m_err;
    int          m_owner, m_rr, m_wait;
    logic [31:0] m_addr, m_wdata;
    bit          m_wen, m_byte;

    function automatic int rr_pick(input logic [N-1:0] v, input int rr);
        for (int d = 0; d < N; d++) begin
            if (v[(rr + d) % N]) return (rr + d) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_open <= 1'b0; m_took <= 1'b0; m_err <= 1'b0;
            m_owner <= 0; m_rr <= 0; m_wait <= 0;
        end else if (!m_open) begin
            if (rr_pick(req_valid_i, m_rr) >= 0) begin
                m_open  <= 1'b1;
                m_took  <= 1'b0;
                m_owner <= rr_pick(req_valid_i, m_rr);
                m_addr  <= 32'(req_addr_i >> (32 * rr_pick(req_valid_i, m_rr)));
                m_wdata <= 32'(req_wdata_i >> (32 * rr_pick(req_valid_i, m_rr)));
                m_wen   <= req_wen_i[rr_pick(req_valid_i, m_rr)];
                m_byte  <= req_byte_i[rr_pick(req_valid_i, m_rr)];
            end
        end else if ((m_took || mem_yumi_i) && mem_valid_i && req_yumi_i[m_owner]) begin
            m_open <= 1'b0;
            m_took <= 1'b0;
            m_rr   <= (m_owner + 1) % N;
        end else if (!m_took && mem_yumi_i) begin
            m_took <= 1'b1;
            m_wait <= 0;
        end else if (m_took && !mem_valid_i) begin
            m_wait <= m_wait + 1;
            if (m_wait + 1 >= TMO) m_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [N-1:0] oh;
            bit issue, win;
            oh    = N'(1) << m_owner;
            issue = m_open && !m_took;
            win   = m_took || (issue && mem_yumi_i);
            chk("busy", busy_o, m_open);
            chk("mem_valid", mem_valid_o, issue);
            chk("grant_id", grant_id_o, m_owner);
            chk("error", error_o, m_err);
            chk("req_yumi", req_yumi_o, (issue && mem_yumi_i) ? oh : '0);
            chk("rsp_valid", rsp_valid_o, (win && mem_valid_i) ? oh : '0);
            chk("rsp_data", rsp_data_o, win ? mem_rdata_i : 32'h0);
            chk("mem_yumi", mem_yumi_o, win && mem_valid_i && req_yumi_i[m_owner]);
            if (issue) begin
                chk("mem_addr", mem_addr_o, m_addr);
                chk("mem_wdata", mem_wdata_o, m_wdata);
                chk("mem_wen", mem_wen_o, m_wen);
                chk("mem_byte", mem_byte_o, m_byte);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    bit [N-1:0] pend;
    bit         mem_owes, resp_on;

    initial begin
        reset = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        nxt();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_grant", grant_id_o, 0);
        chk("rst_memvalid", mem_valid_o, 0);
        nxt();

        // Single load from core1, memory stalls acceptance one cycle
        req_valid_i = 4'b0010; req_addr_i[32 +: 32] = 32'h40;
        @(negedge clk); chk("ld_idle_busy", busy_o, 0); nxt();
        @(negedge clk);
        chk("ld_memvalid", mem_valid_o, 1); chk("ld_addr", mem_addr_o, 32'h40);
        chk("ld_grant", grant_id_o, 1); chk("ld_noyumi", req_yumi_o, 0);
        nxt();
        mem_yumi_i = 1'b1;
        @(negedge clk); chk("ld_reqyumi", req_yumi_o, 4'b0010); nxt();
        req_valid_i = '0; mem_yumi_i = 1'b0;
        @(negedge clk); chk("ld_resp_busy", busy_o, 1); chk("ld_resp_norsp", rsp_valid_o, 0); nxt();
        mem_valid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; req_yumi_i = 4'b0010;
        @(negedge clk);
        chk("ld_rspvalid", rsp_valid_o, 4'b0010); chk("ld_rspdata", rsp_data_o, 32'hDEADBEEF);
        chk("ld_memyumi", mem_yumi_o, 1);
        nxt();
        mem_valid_i = 1'b0; req_yumi_i = '0;
        @(negedge clk); chk("ld_done_idle", busy_o, 0); chk("ld_grant_held", grant_id_o, 1); nxt();

        // rr_ptr is now 2: cores 0 and 2 request, core2 wins; then same-cycle yumi+valid
        req_valid_i = 4'b0101;
        @(negedge clk); nxt();
        mem_yumi_i = 1'b1; mem_valid_i = 1'b1; req_yumi_i = 4'b0100; mem_rdata_i = 32'h12345678;
        @(negedge clk);
        chk("rr_grant2", grant_id_o, 2); chk("same_reqyumi", req_yumi_o, 4'b0100);
        chk("same_rspvalid", rsp_valid_o, 4'b0100); chk("same_memyumi", mem_yumi_o, 1);
        nxt();
        req_valid_i = 4'b0001; mem_yumi_i = 1'b0; mem_valid_i = 1'b0; req_yumi_i = '0;
        @(negedge clk); chk("same_idle", busy_o, 0); nxt();
        mem_yumi_i = 1'b1; mem_valid_i = 1'b1; req_yumi_i = 4'b0001;
        @(negedge clk); chk("rr_wrap_grant0", grant_id_o, 0); chk("wrap_memyumi", mem_yumi_o, 1); nxt();
        clear_inputs();

        // Byte store from core2 with owner stalling the ack for 3 cycles
        req_valid_i = 4'b0100; req_wen_i = 4'b0100; req_byte_i = 4'b0100;
        req_wdata_i[64 +: 32] = 32'hAB; req_addr_i[64 +: 32] = 32'h1003;
        @(negedge clk); nxt();
        mem_yumi_i = 1'b1;
        @(negedge clk);
        chk("st_wen", mem_wen_o, 1); chk("st_byte", mem_byte_o, 1);
        chk("st_wdata", mem_wdata_o, 32'hAB); chk("st_addr", mem_addr_o, 32'h1003);
        nxt();
        req_valid_i = '0; req_wen_i = '0; req_byte_i = '0;
        mem_yumi_i = 1'b0; mem_valid_i = 1'b1; req_yumi_i = 4'b1011;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall_memyumi", mem_yumi_o, 0); chk("stall_busy", busy_o, 1);
            chk("stall_rspvalid", rsp_valid_o, 4'b0100);
            nxt();
        end
        req_yumi_i = 4'b0100;
        @(negedge clk); chk("stall_release", mem_yumi_o, 1); nxt();
        clear_inputs();
        @(negedge clk); chk("st_idle", busy_o, 0); nxt();

        // Fresh reset, then all four cores hammer a single-cycle memory
        reset = 1'b0; nxt(); reset = 1'b1;
        req_valid_i = 4'b1111; req_yumi_i = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            mem_yumi_i = mem_valid_o; mem_valid_i = mem_valid_o; mem_rdata_i = $urandom;
            @(negedge clk);
            chk("rr4_memvalid", mem_valid_o, i % 2);
            if (i % 2 == 1) chk("rr4_grant", grant_id_o, (i / 2) % 4);
            nxt();
        end
        clear_inputs();

        // Timeout: core2 accepted, memory never answers
        req_valid_i = 4'b0100;
        @(negedge clk); nxt();
        mem_yumi_i = 1'b1;
        @(negedge clk); nxt();
        req_valid_i = '0; mem_yumi_i = 1'b0;
        for (int j = 1; j <= TMO; j++) begin
            @(negedge clk); chk("tmo_not_yet", error_o, 0); chk("tmo_busy", busy_o, 1); nxt();
        end
        @(negedge clk); chk("tmo_set", error_o, 1); nxt();
        mem_valid_i = 1'b1; req_yumi_i = 4'b0100;
        @(negedge clk); chk("tmo_late_done", mem_yumi_o, 1); nxt();
        clear_inputs();
        @(negedge clk); chk("tmo_sticky", error_o, 1); chk("tmo_idle", busy_o, 0); nxt();

        // Reset in the middle of RESP (rr_ptr was 3 before it)
        req_valid_i = 4'b0010;
        @(negedge clk); nxt();
        mem_yumi_i = 1'b1;
        @(negedge clk); chk("mid_grant1", grant_id_o, 1); nxt();
        req_valid_i = '0; mem_yumi_i = 1'b0;
        @(negedge clk); chk("mid_in_resp", busy_o, 1); nxt();
        reset = 1'b0; mem_valid_i = 1'b1; req_yumi_i = 4'b0010; mem_rdata_i = 32'hCAFE0001;
        @(negedge clk); nxt();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy_o, 0); chk("mid_rst_memvalid", mem_valid_o, 0);
        chk("mid_rst_error", error_o, 0); chk("mid_rst_rspvalid", rsp_valid_o, 0);
        chk("mid_rst_memyumi", mem_yumi_o, 0); chk("mid_rst_rspdata", rsp_data_o, 0);
        chk("mid_rst_grant", grant_id_o, 0); chk("mid_rst_reqyumi", req_yumi_o, 0);
        nxt();
        clear_inputs();
        req_valid_i = 4'b1010;
        @(negedge clk); nxt();
        @(negedge clk); chk("mid_rst_rrptr", grant_id_o, 1); nxt();
        reset = 1'b0; clear_inputs(); nxt(); reset = 1'b1;

        // Random traffic against the model
        pend = '0; mem_owes = 1'b0; resp_on = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 750 == 749) begin
                reset = 1'b0;
                clear_inputs();
                pend = '0; mem_owes = 1'b0; resp_on = 1'b0;
            end else begin
                reset = 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (!pend[k]) begin
                        req_valid_i[k] = 1'b0;
                        if ($urandom_range(0, 2) == 0) begin
                            pend[k] = 1'b1;
                            req_valid_i[k] = 1'b1;
                            req_wen_i[k]   = 1'($urandom);
                            req_byte_i[k]  = 1'($urandom);
                            req_addr_i[32*k +: 32]  = $urandom;
                            req_wdata_i[32*k +: 32] = $urandom;
                        end
                    end
                end
                req_yumi_i = N'($urandom);
                mem_yumi_i = mem_valid_o && ($urandom_range(0, 2) != 0);
                if (resp_on) begin
                    mem_valid_i = 1'b1;
                end else if ((mem_owes || mem_yumi_i) && $urandom_range(0, 1) == 1) begin
                    resp_on = 1'b1;
                    mem_valid_i = 1'b1;
                    mem_rdata_i = $urandom;
                end else begin
                    mem_valid_i = 1'b0;
                end
            end
            @(negedge clk);
            if (reset) begin
                for (int k = 0; k < N; k++) begin
                    if (req_yumi_o[k]) pend[k] = 1'b0;
                end
                if (mem_valid_o && mem_yumi_i) mem_owes = 1'b1;
                if (mem_yumi_o) begin
                    mem_owes = 1'b0;
                    resp_on = 1'b0;
                end
            end
            nxt();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
